// File: rtl/de_arbiter.sv
// ---------------------------------------------------------------------------
// de_arbiter
//   Two-port arbiter in front of a single frame-store (display engine) port.
//   One requester owns the port at a time; a port keeps ownership for up to
//   MAX_BURST acknowledged transfers while the other port waits, after which
//   ownership moves straight across with no idle cycle. A transfer in flight
//   (de_req high, de_ack not yet seen) is never split or re-targeted.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m0_req  / m1_req         per-requester transfer request (held for a burst)
//   m0_ack  / m1_ack         per-transfer acknowledge back to the requester
//   m0_addr / m1_addr        18-bit word address
//   m0_nbyte/ m1_nbyte       active-low byte enables
//   m0_rnw  / m1_rnw         1 = read, 0 = write
//   m0_w_data/m1_w_data      write data
//   m_r_data                 read data, broadcast to both requesters
//   de_req, de_ack           frame-store request / one-cycle acknowledge
//   de_addr, de_nbyte,
//   de_rnw, de_w_data        command muxed from the current owner
//   de_r_data                frame-store read data
//   grant                    one-hot owner: 01 port 0, 10 port 1, 00 none
// ---------------------------------------------------------------------------
module de_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    output logic        m0_ack,
    input  logic [17:0] m0_addr,
    input  logic [3:0]  m0_nbyte,
    input  logic        m0_rnw,
    input  logic [31:0] m0_w_data,

    input  logic        m1_req,
    output logic        m1_ack,
    input  logic [17:0] m1_addr,
    input  logic [3:0]  m1_nbyte,
    input  logic        m1_rnw,
    input  logic [31:0] m1_w_data,

    output logic [31:0] m_r_data,

    output logic        de_req,
    input  logic        de_ack,
    output logic [17:0] de_addr,
    output logic [3:0]  de_nbyte,
    output logic        de_rnw,
    output logic [31:0] de_w_data,
    input  logic [31:0] de_r_data,

    output logic [1:0]  grant
);

    localparam int unsigned        LP_CW    = 5;
    localparam logic [LP_CW-1:0]   LP_LIMIT = LP_CW'(MAX_BURST - 1);
    localparam logic [LP_CW-1:0]   LP_SAT   = '1;

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LP_CW-1:0]   r_cnt;
    logic [LP_CW-1:0]   w_next_cnt;
    logic               r_last_owner;
    logic               w_next_last;
    logic               w_at_limit;

    // Owner has used its share. ">=" rather than "==" so that an owner that
    // ran past the limit while the other side was idle still hands over on
    // its next ack once the other side starts requesting.
    assign w_at_limit = (r_cnt >= LP_LIMIT);

    // State, burst counter and last-owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_last_owner <= w_next_last;
        end
    end

    // Next-state, last-owner and burst-count logic.
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last_owner;
        w_next_cnt   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                // Tie goes to the port that did not own the bus last.
                if (m0_req && m1_req) begin
                    w_next_state = r_last_owner ? ST_G0 : ST_G1;
                end else if (m0_req) begin
                    w_next_state = ST_G0;
                end else if (m1_req) begin
                    w_next_state = ST_G1;
                end
            end

            ST_G0: begin
                // Release needs de_req (= m0_req) low, and a switch needs
                // de_ack, so a pending transfer is never re-targeted.
                if (!m0_req) begin
                    w_next_state = m1_req ? ST_G1 : ST_IDLE;
                    w_next_last  = 1'b0;
                end else if (de_ack && m1_req && w_at_limit) begin
                    w_next_state = ST_G1;
                    w_next_last  = 1'b0;
                end
            end

            ST_G1: begin
                if (!m1_req) begin
                    w_next_state = m0_req ? ST_G0 : ST_IDLE;
                    w_next_last  = 1'b1;
                end else if (de_ack && m0_req && w_at_limit) begin
                    w_next_state = ST_G0;
                    w_next_last  = 1'b1;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Count acks within one ownership; restart on any grant change.
        if (w_next_state != r_state) begin
            w_next_cnt = '0;
        end else if ((r_state != ST_IDLE) && de_ack && (r_cnt != LP_SAT)) begin
            w_next_cnt = r_cnt + LP_CW'(1);
        end
    end

    // Command mux and ack steering; IDLE presents a harmless read with no
    // byte lanes enabled.
    always_comb begin
        de_req    = 1'b0;
        de_addr   = '0;
        de_nbyte  = '1;
        de_rnw    = 1'b1;
        de_w_data = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;

        case (r_state)
            ST_G0: begin
                de_req    = m0_req;
                de_addr   = m0_addr;
                de_nbyte  = m0_nbyte;
                de_rnw    = m0_rnw;
                de_w_data = m0_w_data;
                m0_ack    = de_ack;
            end
            ST_G1: begin
                de_req    = m1_req;
                de_addr   = m1_addr;
                de_nbyte  = m1_nbyte;
                de_rnw    = m1_rnw;
                de_w_data = m1_w_data;
                m1_ack    = de_ack;
            end
            default: begin
            end
        endcase
    end

    assign grant    = r_state;
    assign m_r_data = de_r_data;

endmodule

// File: tb/tb_de_arbiter.sv
// ---------------------------------------------------------------------------
// tb_de_arbiter
//   Directed bench for de_arbiter with MAX_BURST = 4. Inputs change 1 ns
//   after the rising edge, outputs are checked 2 ns after it.
// ---------------------------------------------------------------------------
module tb_de_arbiter;

    localparam int unsigned LP_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req;
    logic        m0_ack, m1_ack;
    logic [17:0] m0_addr, m1_addr;
    logic [3:0]  m0_nbyte, m1_nbyte;
    logic        m0_rnw, m1_rnw;
    logic [31:0] m0_w_data, m1_w_data;
    logic [31:0] m_r_data;
    logic        de_req, de_ack;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic        de_rnw;
    logic [31:0] de_w_data, de_r_data;
    logic [1:0]  grant;

    int n_tests = 0;
    int n_fail  = 0;

    de_arbiter #(.MAX_BURST(LP_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_ack    (m0_ack),
        .m0_addr   (m0_addr),
        .m0_nbyte  (m0_nbyte),
        .m0_rnw    (m0_rnw),
        .m0_w_data (m0_w_data),
        .m1_req    (m1_req),
        .m1_ack    (m1_ack),
        .m1_addr   (m1_addr),
        .m1_nbyte  (m1_nbyte),
        .m1_rnw    (m1_rnw),
        .m1_w_data (m1_w_data),
        .m_r_data  (m_r_data),
        .de_req    (de_req),
        .de_ack    (de_ack),
        .de_addr   (de_addr),
        .de_nbyte  (de_nbyte),
        .de_rnw    (de_rnw),
        .de_w_data (de_w_data),
        .de_r_data (de_r_data),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g;
        int         n_ack0;
        int         n_ack1;
        int         n_badg;

        rst       = 1'b1;
        m0_req    = 1'b0;
        m1_req    = 1'b0;
        m0_addr   = '0;
        m1_addr   = '0;
        m0_nbyte  = 4'hF;
        m1_nbyte  = 4'hF;
        m0_rnw    = 1'b1;
        m1_rnw    = 1'b1;
        m0_w_data = '0;
        m1_w_data = '0;
        de_ack    = 1'b0;
        de_r_data = '0;

        // Reset holds IDLE outputs even with requests and acks present.
        repeat (3) cyc();
        m0_req = 1'b1;
        de_ack = 1'b1;
        #1;
        chk("rst_grant",  64'(grant),    64'h0);
        chk("rst_de_req", 64'(de_req),   64'h0);
        chk("rst_m0_ack", 64'(m0_ack),   64'h0);
        chk("rst_nbyte",  64'(de_nbyte), 64'hF);
        chk("rst_rnw",    64'(de_rnw),   64'h1);
        chk("rst_addr",   64'(de_addr),  64'h0);
        chk("rst_wdata",  64'(de_w_data),64'h0);
        cyc();
        chk("rst_hold",   64'(grant),    64'h0);
        m0_req = 1'b0;
        de_ack = 1'b0;

        // Release reset, both request: port 0 wins first tie, one-cycle latency.
        cyc();
        rst    = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        #1;
        chk("lat_idle_de_req", 64'(de_req), 64'h0);
        cyc();
        chk("tie0_grant",  64'(grant),  64'h1);
        chk("tie0_de_req", 64'(de_req), 64'h1);

        // Command mux and read data broadcast.
        m0_addr   = 18'h12345;
        m0_nbyte  = 4'b1101;
        m0_rnw    = 1'b0;
        m0_w_data = 32'hDEADBEEF;
        m1_addr   = 18'h3FFFF;
        m1_nbyte  = 4'b0000;
        m1_rnw    = 1'b1;
        m1_w_data = 32'h01234567;
        de_r_data = 32'hA5A5A5A5;
        #1;
        chk("mux_addr",   64'(de_addr),   64'h12345);
        chk("mux_nbyte",  64'(de_nbyte),  64'hD);
        chk("mux_rnw",    64'(de_rnw),    64'h0);
        chk("mux_wdata",  64'(de_w_data), 64'hDEADBEEF);
        chk("mux_rdata",  64'(m_r_data),  64'hA5A5A5A5);

        // Fairness: acks every cycle, ownership alternates every 4 acks.
        for (int i = 0; i < 12; i++) begin
            cyc();
            de_ack = 1'b1;
            #1;
            exp_g = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
            chk($sformatf("fair_grant_%0d", i), 64'(grant),  64'(exp_g));
            chk($sformatf("fair_ack0_%0d", i),  64'(m0_ack), 64'(exp_g[0]));
            chk($sformatf("fair_ack1_%0d", i),  64'(m1_ack), 64'(exp_g[1]));
        end
        cyc();
        de_ack = 1'b0;
        #1;
        chk("fair_wrap_grant", 64'(grant),     64'h2);
        chk("mux1_addr",       64'(de_addr),   64'h3FFFF);
        chk("mux1_nbyte",      64'(de_nbyte),  64'h0);
        chk("mux1_wdata",      64'(de_w_data), 64'h01234567);
        chk("mux1_de_req",     64'(de_req),    64'h1);

        // Reset pulsed mid-cycle drops the grant before the next edge.
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_grant",  64'(grant),    64'h0);
        chk("midrst_de_req", 64'(de_req),   64'h0);
        chk("midrst_nbyte",  64'(de_nbyte), 64'hF);
        cyc();
        rst = 1'b0;
        cyc();
        chk("postrst_tie_grant", 64'(grant), 64'h1);

        // No split: port 1 arrives while port 0 (count 3) awaits its ack.
        m1_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            de_ack = 1'b1;
            #1;
            chk($sformatf("nosplit_ack_%0d", k), 64'(m0_ack), 64'h1);
        end
        cyc();
        de_ack = 1'b0;
        m1_req = 1'b1;
        #1;
        chk("nosplit_hold0", 64'(grant), 64'h1);
        cyc();
        chk("nosplit_hold1", 64'(grant),  64'h1);
        chk("nosplit_m1ack", 64'(m1_ack), 64'h0);
        cyc();
        de_ack = 1'b1;
        #1;
        chk("nosplit_ackcyc", 64'(grant),  64'h1);
        chk("nosplit_m0ack",  64'(m0_ack), 64'h1);
        cyc();
        de_ack = 1'b0;
        #1;
        chk("nosplit_switch", 64'(grant), 64'h2);

        // Release: port 1 drops -> port 0; port 0 drops -> IDLE; tie -> port 1.
        m1_req = 1'b0;
        cyc();
        chk("rel_to_g0", 64'(grant), 64'h1);
        m0_req = 1'b0;
        #1;
        chk("rel_de_req_comb", 64'(de_req), 64'h0);
        cyc();
        chk("rel_idle_grant", 64'(grant),    64'h0);
        chk("rel_idle_nbyte", 64'(de_nbyte), 64'hF);
        chk("rel_idle_addr",  64'(de_addr),  64'h0);
        m0_req = 1'b1;
        m1_req = 1'b1;
        cyc();
        chk("rel_tie_grant", 64'(grant), 64'h2);

        // Single requester: 40 ack pulses, port 1 keeps the grant.
        m0_req = 1'b0;
        n_ack0 = 0;
        n_ack1 = 0;
        n_badg = 0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            de_ack = ((i % 2) == 0);
            #1;
            if (m0_ack) n_ack0++;
            if (m1_ack) n_ack1++;
            if (grant !== 2'b10) n_badg++;
        end
        chk("single_m1_acks", 64'(n_ack1), 64'd40);
        chk("single_m0_acks", 64'(n_ack0), 64'd0);
        chk("single_bad_grant_cycles", 64'(n_badg), 64'd0);

        // Ack and request drop in the same cycle: ack delivered, then release.
        cyc();
        de_ack = 1'b1;
        m1_req = 1'b0;
        #1;
        chk("drop_ack_m1", 64'(m1_ack), 64'h1);
        cyc();
        de_ack = 1'b0;
        #1;
        chk("drop_idle", 64'(grant), 64'h0);

        // Stray ack in IDLE is ignored.
        de_ack = 1'b1;
        #1;
        chk("idle_ack_m0", 64'(m0_ack), 64'h0);
        chk("idle_ack_m1", 64'(m1_ack), 64'h0);
        cyc();
        de_ack = 1'b0;
        #1;
        chk("idle_ack_state", 64'(grant), 64'h0);

        // Lone port-1 request from IDLE.
        m1_req = 1'b1;
        #1;
        chk("lone1_lat0", 64'(de_req), 64'h0);
        cyc();
        chk("lone1_grant",  64'(grant),  64'h2);
        chk("lone1_de_req", 64'(de_req), 64'h1);
        m1_req = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/de_arbiter.md
DE_ARBITER -- requirements
Module: de_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16, is the number of consecutive de_ack transfers a grantee may take while the other port waits; legal range 1..31.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 m0_req / m1_req  input  1  requester 0/1 transfer request, held high for a burst.
REQ-005 m0_ack / m1_ack  output  1  per-transfer acknowledge to requester 0/1.
REQ-006 m0_addr / m1_addr  input  18  word address from requester 0/1.
REQ-007 m0_nbyte / m1_nbyte  input  4  active-low byte enables from requester 0/1.
REQ-008 m0_rnw / m1_rnw  input  1  1 = read, 0 = write, from requester 0/1.
REQ-009 m0_w_data / m1_w_data  input  32  write data from requester 0/1.
REQ-010 m_r_data  output  32  read data, broadcast to both requesters.
REQ-011 de_req  output  1  request to the frame-store port.
REQ-012 de_ack  input  1  frame-store acknowledge, one-cycle pulse per transfer.
REQ-013 de_addr, de_nbyte, de_rnw, de_w_data  output  18/4/1/32  muxed from the granted requester.
REQ-014 de_r_data  input  32  frame-store read data.
REQ-015 grant  output  2  one-hot owner: 01 = port 0, 10 = port 1, 00 = none.

Function
REQ-016 States: IDLE (grant 00), G0 (grant 01), G1 (grant 10); the state is registered.
REQ-017 IDLE with exactly one req high moves to that port's state on the next edge.
REQ-018 IDLE with both req high grants the port not in last_owner; last_owner resets to 1, so port 0 wins the first tie.
REQ-019 In Gn: de_req = mn_req, combinationally.
REQ-020 In Gn: de_addr, de_nbyte, de_rnw and de_w_data equal the port n inputs.
REQ-021 In IDLE: de_req = 0, de_addr = 0, de_nbyte = 4'b1111, de_rnw = 1, de_w_data = 0.
REQ-022 mn_ack = de_ack while in Gn, else 0; the non-granted ack is always 0.
REQ-023 m_r_data = de_r_data unconditionally.
REQ-024 Burst counter, 5 bits: cleared on every grant change, incremented on each de_ack in Gn, saturating at 31.
REQ-025 Switch rule: in Gn, on a de_ack cycle with count = MAX_BURST-1 and the other req high, move directly to the other state next edge; last_owner <= n.
REQ-026 Release rule: in Gn with mn_req low, move next edge to the other state if its req is high, else to IDLE; last_owner <= n.
REQ-027 Ownership never changes while de_req is high and de_ack is low, so a transfer is never split or re-targeted.
REQ-028 At the burst limit with the other req low, keep the grant and continue counting with saturation.
REQ-029 Simultaneous de_ack and drop of mn_req in the same cycle: the ack is delivered to n, then the release rule applies.
REQ-030 Latency: first de_req is asserted one cycle after mn_req rises from IDLE; there is zero dead cycles on a direct G0<->G1 switch.
REQ-031 de_ack seen in IDLE is ignored, with no state change and no ack forwarded.

Reset
REQ-032 rst forces state IDLE, grant 00, counter 0, last_owner 1 immediately, independent of clk.
REQ-033 While rst is high: de_req = 0, m0_ack = 0, m1_ack = 0, and the other outputs take their IDLE values.
REQ-034 rst asserted mid-burst drops de_req asynchronously.
REQ-035 After rst falls, arbitration restarts from IDLE on the first edge with port 0 favoured.

Verification
REQ-036 Reset: rst pulsed mid-clock -> grant=00, de_req=0 before the next edge; after release, both req high -> grant=01.
REQ-037 Single requester: m1_req high, 40 de_acks, m0 idle -> grant stays 10; m1_ack pulses 40 times; m0_ack never pulses.
REQ-038 Fairness, MAX_BURST=4: both req held high -> grant sequence 01,01,01,01,10,10,10,10,01,..., switching on the 4th ack edge with no IDLE cycle.
REQ-039 No split: m1_req rises while port 0 awaits de_ack (count=3, MAX_BURST=4) -> grant holds 01 until the ack, then 10.
REQ-040 Release: m0_req drops with m1_req low -> IDLE next edge and de_nbyte=1111; then m0_req and m1_req rise together -> grant=10, because last_owner=0.
REQ-041 Mux check: grant 01, m0_addr=0x12345, m0_nbyte=1101, m0_rnw=0 -> de_addr=0x12345, de_nbyte=1101, de_rnw=0; de_r_data=0xA5A5A5A5 -> m_r_data=0xA5A5A5A5.
